// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite memory-test master: delay, write one pass, then read-check passes.
module ahb_lite_mem_tester #(
  parameter int unsigned WORD_COUNT     = 16000,
  parameter int unsigned ADDR_INCREMENT = 4,
  parameter int unsigned BURST_MODE     = 0,
  parameter int unsigned PATTERN        = 0,
  parameter logic [31:0] LFSR_SEED      = 32'h1,
  parameter int unsigned DELAY_BITS     = 21,
  parameter logic [7:0]  PASS_CNT       = 8'hff
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HSEL,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] STARTADDR,
  output logic [31:0] ERRCOUNT,
  output logic [7:0]  PASSCOUNT,
  output logic [31:0] FIRSTERR,
  output logic        S_WRITE,
  output logic        S_CHECK,
  output logic        S_SUCCESS,
  output logic        S_FAILED
);

  localparam int unsigned       CNT_W     = $clog2(WORD_COUNT);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(WORD_COUNT - 1);
  localparam logic [1:0]        TR_IDLE   = 2'd0;
  localparam logic [1:0]        TR_NONSEQ = 2'd2;
  localparam logic [1:0]        TR_SEQ    = 2'd3;
  localparam logic [2:0]        BURST_VAL = (BURST_MODE != 0) ? 3'd3 : 3'd0;
  localparam logic [31:0]       LFSR_POLY = 32'h80200003;

  typedef enum logic [1:0] {ST_DELAY, ST_WRITE, ST_READ, ST_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DELAY_BITS-1:0] r_dly;
  logic [1:0]            r_htrans;
  logic [31:0]           r_haddr;
  logic [2:0]            r_hburst;
  logic                  r_hwrite;
  logic [31:0]           r_hwdata;
  logic [CNT_W-1:0]      r_acnt;
  logic                  r_dp_valid, r_dp_write, r_dp_last;
  logic [31:0]           r_dp_addr;
  logic [31:0]           r_lfsr;
  logic [31:0]           r_errcount, r_firsterr;
  logic [7:0]            r_passcount;
  logic                  r_s_write, r_s_check, r_s_success, r_s_failed;
  logic                  w_s_write_nxt, w_s_check_nxt, w_s_success_nxt, w_s_failed_nxt;

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] f_pattern(input logic [31:0] addr, input logic [31:0] lfsr);
    if (PATTERN == 0) return addr;
    else if (PATTERN == 1) return ~addr;
    return lfsr;
  endfunction

  logic             w_dly_done, w_addr_busy, w_last_addr, w_pass_end, w_final_pass;
  logic             w_start_pass, w_beat_done, w_beat_err;
  logic [CNT_W-1:0] w_next_idx;
  logic [31:0]      w_exp, w_wdata;

  assign w_dly_done   = &r_dly;
  assign w_addr_busy  = (r_htrans != TR_IDLE);
  assign w_last_addr  = (r_acnt == LAST_IDX);
  assign w_pass_end   = r_dp_valid && r_dp_last && HREADY;
  assign w_final_pass = (PASS_CNT != 8'd0) && (8'(r_passcount + 8'd1) == PASS_CNT);
  assign w_start_pass = HREADY && (w_state_nxt == ST_WRITE || w_state_nxt == ST_READ) &&
                        (r_state == ST_DELAY || w_pass_end);
  assign w_next_idx   = CNT_W'(r_acnt + CNT_W'(1));
  assign w_exp        = f_pattern(r_dp_addr, r_lfsr);
  // A write beat's data uses the LFSR value after the completing beat (if any) advances it.
  assign w_wdata      = f_pattern(r_haddr, r_dp_valid ? f_lfsr_step(r_lfsr) : r_lfsr);
  assign w_beat_done  = r_dp_valid && HREADY;
  assign w_beat_err   = w_beat_done && (HRESP || (!r_dp_write && (HRDATA != w_exp)));

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_DELAY;
    else          r_state <= w_state_nxt;
  end

  // Next-state: pass boundaries are the completion of a pass's last data phase
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_DELAY: if (w_dly_done && HREADY) w_state_nxt = ST_WRITE;
      ST_WRITE: if (w_pass_end) w_state_nxt = ST_READ;
      ST_READ:  if (w_pass_end && w_final_pass) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_DONE;
    endcase
  end

  // Status flag next values; DONE verdict uses the already-updated error count
  always_comb begin
    w_s_write_nxt   = (w_state_nxt == ST_WRITE);
    w_s_check_nxt   = (w_state_nxt == ST_READ);
    w_s_success_nxt = (r_state == ST_DONE) && (r_errcount == 32'd0);
    w_s_failed_nxt  = (r_state == ST_DONE) && (r_errcount != 32'd0);
  end

  // Bus pipeline, pattern generator, checker and counters
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dly       <= '0;
      r_htrans    <= TR_IDLE;
      r_haddr     <= '0;
      r_hburst    <= '0;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_acnt      <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_last   <= 1'b0;
      r_dp_addr   <= '0;
      r_lfsr      <= LFSR_SEED;
      r_errcount  <= '0;
      r_firsterr  <= '0;
      r_passcount <= '0;
      r_s_write   <= 1'b0;
      r_s_check   <= 1'b0;
      r_s_success <= 1'b0;
      r_s_failed  <= 1'b0;
    end else begin
      r_s_write   <= w_s_write_nxt;
      r_s_check   <= w_s_check_nxt;
      r_s_success <= w_s_success_nxt;
      r_s_failed  <= w_s_failed_nxt;

      if (r_state == ST_DELAY && !w_dly_done) r_dly <= r_dly + DELAY_BITS'(1);

      if (HREADY) begin
        r_dp_valid <= w_addr_busy;
        if (w_addr_busy) begin
          r_dp_addr  <= r_haddr;
          r_dp_write <= r_hwrite;
          r_dp_last  <= w_last_addr;
          if (r_hwrite) r_hwdata <= w_wdata;
        end
        if (w_start_pass) begin
          r_acnt   <= '0;
          r_haddr  <= STARTADDR;
          r_htrans <= TR_NONSEQ;
          r_hburst <= BURST_VAL;
          r_hwrite <= (w_state_nxt == ST_WRITE);
        end else if (w_addr_busy && !w_last_addr) begin
          r_acnt   <= w_next_idx;
          r_haddr  <= r_haddr + 32'(ADDR_INCREMENT);
          r_htrans <= ((BURST_MODE != 0) && (w_next_idx[1:0] != 2'b00)) ? TR_SEQ : TR_NONSEQ;
        end else begin
          r_htrans <= TR_IDLE;
          r_hburst <= '0;
          r_hwrite <= 1'b0;
        end
      end

      if (w_beat_done) begin
        r_lfsr <= r_dp_last ? LFSR_SEED : f_lfsr_step(r_lfsr);
        if (w_beat_err) begin
          if (r_errcount != 32'hFFFF_FFFF) r_errcount <= r_errcount + 32'd1;
          if (r_errcount == 32'd0)         r_firsterr <= r_dp_addr;
        end
        if (!r_dp_write && r_dp_last) r_passcount <= r_passcount + 8'd1;
      end
    end
  end

  assign HADDR     = r_haddr;
  assign HBURST    = r_hburst;
  assign HSEL      = (r_htrans != TR_IDLE);
  assign HSIZE     = 3'd2;
  assign HTRANS    = r_htrans;
  assign HWDATA    = r_hwdata;
  assign HWRITE    = r_hwrite;
  assign ERRCOUNT  = r_errcount;
  assign PASSCOUNT = r_passcount;
  assign FIRSTERR  = r_firsterr;
  assign S_WRITE   = r_s_write;
  assign S_CHECK   = r_s_check;
  assign S_SUCCESS = r_s_success;
  assign S_FAILED  = r_s_failed;

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Bench: burst/LFSR tester (dut A) with fault-injecting slave, plus single/address tester (dut B).
module tb_ahb_lite_mem_tester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] startaddr = 32'h100;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  // dut A signals
  logic [31:0] a_haddr, a_hwdata, a_hrdata, a_errcount, a_firsterr;
  logic [2:0]  a_hburst, a_hsize;
  logic [1:0]  a_htrans;
  logic        a_hsel, a_hwrite, a_hready, a_hresp;
  logic [7:0]  a_passcount;
  logic        a_sw, a_sc, a_ss, a_sf;
  // dut B signals
  logic [31:0] b_haddr, b_hwdata, b_hrdata, b_errcount, b_firsterr;
  logic [2:0]  b_hburst, b_hsize;
  logic [1:0]  b_htrans;
  logic        b_hsel, b_hwrite;
  logic [7:0]  b_passcount;
  logic        b_sw, b_sc, b_ss, b_sf;

  ahb_lite_mem_tester #(.WORD_COUNT(8), .ADDR_INCREMENT(4), .BURST_MODE(1), .PATTERN(2),
    .LFSR_SEED(32'h1), .DELAY_BITS(2), .PASS_CNT(8'd3)) dut_a (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(a_haddr), .HBURST(a_hburst), .HSEL(a_hsel),
    .HSIZE(a_hsize), .HTRANS(a_htrans), .HWDATA(a_hwdata), .HWRITE(a_hwrite),
    .HRDATA(a_hrdata), .HREADY(a_hready), .HRESP(a_hresp), .STARTADDR(startaddr),
    .ERRCOUNT(a_errcount), .PASSCOUNT(a_passcount), .FIRSTERR(a_firsterr),
    .S_WRITE(a_sw), .S_CHECK(a_sc), .S_SUCCESS(a_ss), .S_FAILED(a_sf));

  ahb_lite_mem_tester #(.WORD_COUNT(8), .ADDR_INCREMENT(4), .BURST_MODE(0), .PATTERN(0),
    .LFSR_SEED(32'h1), .DELAY_BITS(2), .PASS_CNT(8'd2)) dut_b (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(b_haddr), .HBURST(b_hburst), .HSEL(b_hsel),
    .HSIZE(b_hsize), .HTRANS(b_htrans), .HWDATA(b_hwdata), .HWRITE(b_hwrite),
    .HRDATA(b_hrdata), .HREADY(1'b1), .HRESP(1'b0), .STARTADDR(startaddr),
    .ERRCOUNT(b_errcount), .PASSCOUNT(b_passcount), .FIRSTERR(b_firsterr),
    .S_WRITE(b_sw), .S_CHECK(b_sc), .S_SUCCESS(b_ss), .S_FAILED(b_sf));

  // Slave A: memory with optional wait states, read corruption and error response
  logic [31:0] a_mem [8];
  logic        a_dv, a_dw;
  logic [31:0] a_da;
  int          a_wait_left;
  int          a_rd10c;
  logic        a_wait_used;
  logic        wait_en = 1'b0, corrupt_en = 1'b0, resp_en = 1'b0;

  assign a_hready = (a_wait_left == 0);
  assign a_hresp  = a_dv && !a_dw && resp_en && (a_da == 32'h104);
  assign a_hrdata = a_mem[a_da[4:2]] ^
                    {31'd0, corrupt_en && a_dv && !a_dw && (a_da == 32'h10C) && (a_rd10c == 0)};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dv <= 1'b0; a_dw <= 1'b0; a_da <= '0;
      a_wait_left <= 0; a_rd10c <= 0; a_wait_used <= 1'b0;
    end else begin
      if (a_wait_left != 0) a_wait_left <= a_wait_left - 1;
      if (a_hready) begin
        if (a_dv && a_dw) a_mem[a_da[4:2]] <= a_hwdata;
        if (a_dv && !a_dw && a_da == 32'h10C) a_rd10c <= a_rd10c + 1;
        a_dv <= (a_htrans != 2'd0);
        a_da <= a_haddr;
        a_dw <= a_hwrite;
        if (a_htrans != 2'd0 && a_hwrite && a_haddr == 32'h114 && wait_en && !a_wait_used) begin
          a_wait_left <= 3;
          a_wait_used <= 1'b1;
        end
      end
    end
  end

  // Slave B: zero-wait memory
  logic [31:0] b_mem [8];
  logic        b_dv, b_dw;
  logic [31:0] b_da;
  assign b_hrdata = b_mem[b_da[4:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_dv <= 1'b0; b_dw <= 1'b0; b_da <= '0;
    end else begin
      if (b_dv && b_dw) b_mem[b_da[4:2]] <= b_hwdata;
      b_dv <= (b_htrans != 2'd0);
      b_da <= b_haddr;
      b_dw <= b_hwrite;
    end
  end

  logic [63:0] a_log [$];
  logic [63:0] b_log [$];
  logic        p_hready = 1'b1;
  logic [31:0] p_haddr, p_hwdata;
  logic [1:0]  p_htrans;
  logic [2:0]  p_hburst;
  logic        p_hwrite;

  function automatic logic [31:0] lfsr_k(input int k);
    logic [31:0] v;
    v = 32'h1;
    for (int i = 0; i < k; i++) v = {1'b0, v[31:1]} ^ (v[0] ? 32'h80200003 : 32'h0);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, run per-cycle protocol checks, log accepted beats
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("a_hsel", 64'(a_hsel), 64'(a_htrans != 2'd0));
    chk("b_hsel", 64'(b_hsel), 64'(b_htrans != 2'd0));
    chk("a_hsize", 64'(a_hsize), 64'd2);
    if (!p_hready && rst_n) begin
      chk("hold_haddr", 64'(a_haddr), 64'(p_haddr));
      chk("hold_htrans", 64'(a_htrans), 64'(p_htrans));
      chk("hold_hburst", 64'(a_hburst), 64'(p_hburst));
      chk("hold_hwrite", 64'(a_hwrite), 64'(p_hwrite));
      chk("hold_hwdata", 64'(a_hwdata), 64'(p_hwdata));
    end
    if (a_hready && a_htrans != 2'd0) a_log.push_back({26'd0, a_hwrite, a_hburst, a_htrans, a_haddr});
    if (b_htrans != 2'd0) b_log.push_back({26'd0, b_hwrite, b_hburst, b_htrans, b_haddr});
    if (a_dv && a_dw && a_hready) chk("a_wdata", 64'(a_hwdata), 64'(lfsr_k(int'(a_da[4:2]))));
    if (b_dv && b_dw) chk("b_wdata", 64'(b_hwdata), 64'(b_da));
    p_hready = a_hready; p_haddr = a_haddr; p_htrans = a_htrans;
    p_hburst = a_hburst; p_hwrite = a_hwrite; p_hwdata = a_hwdata;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_haddr"}, 64'(a_haddr), 64'd0);
    chk({tag, "_htrans"}, 64'(a_htrans), 64'd0);
    chk({tag, "_hburst"}, 64'(a_hburst), 64'd0);
    chk({tag, "_hwrite"}, 64'(a_hwrite), 64'd0);
    chk({tag, "_hsel"}, 64'(a_hsel), 64'd0);
    chk({tag, "_hwdata"}, 64'(a_hwdata), 64'd0);
    chk({tag, "_errcount"}, 64'(a_errcount), 64'd0);
    chk({tag, "_passcount"}, 64'(a_passcount), 64'd0);
    chk({tag, "_firsterr"}, 64'(a_firsterr), 64'd0);
    chk({tag, "_flags"}, 64'({a_sw, a_sc, a_ss, a_sf}), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs(tag);
    rst_n = 1'b1;
    cyc = 0;
    p_hready = 1'b1;
    a_log.delete();
    b_log.delete();
  endtask

  // Runs until dut A reports a verdict; records first cycles of interest
  task automatic run_to_done(output int a_done, output int b_done, output int chk_cyc);
    a_done = 0; b_done = 0; chk_cyc = 0;
    for (int i = 0; i < 300 && a_done == 0; i++) begin
      tick();
      if (chk_cyc == 0 && a_sc) chk_cyc = cyc;
      if (b_done == 0 && (b_ss || b_sf)) b_done = cyc;
      if (a_ss || a_sf) a_done = cyc;
    end
    chk("done_within_budget", 64'(a_done != 0), 64'd1);
  endtask

  task automatic chk_a_log(input string tag);
    logic [63:0] e;
    chk({tag, "_nbeats"}, 64'(a_log.size()), 64'd32);
    for (int k = 0; k < 32 && k < a_log.size(); k++) begin
      e = {26'd0, (k < 8), 3'd3, ((k % 4) == 0) ? 2'd2 : 2'd3, 32'h100 + 32'(4 * (k % 8))};
      chk({tag, "_beat"}, a_log[k], e);
    end
  endtask

  task automatic chk_a_mem(input string tag);
    for (int k = 0; k < 8; k++) chk({tag, "_mem"}, 64'(a_mem[k]), 64'(lfsr_k(k)));
  endtask

  int a_done, b_done, chk_cyc;

  initial begin
    // Scenario A: clean runs on both testers
    do_reset("rstA");
    repeat (3) tick();
    chk("a_idle_before_delay_end", 64'(a_htrans), 64'd0);
    tick();
    chk("a_first_nonseq_cycle", 64'({a_htrans, a_hwrite, a_sw, a_haddr}), {29'd0, 2'd2, 1'b1, 1'b1, 32'h100});
    chk("b_first_nonseq_cycle", 64'({b_htrans, b_hwrite, b_sw}), 64'({2'd2, 1'b1, 1'b1}));
    run_to_done(a_done, b_done, chk_cyc);
    chk("a_done_cycle", 64'(a_done), 64'd41);
    chk("b_done_cycle", 64'(b_done), 64'd32);
    chk("a_check_cycle", 64'(chk_cyc), 64'd13);
    chk("a_result", 64'({a_passcount, a_errcount, a_ss, a_sf}), {22'd0, 8'd3, 32'd0, 1'b1, 1'b0});
    chk("a_firsterr_clean", 64'(a_firsterr), 64'd0);
    chk_a_log("A");
    chk_a_mem("A");
    chk("b_result", 64'({b_passcount, b_errcount, b_ss, b_sf}), {22'd0, 8'd2, 32'd0, 1'b1, 1'b0});
    chk("b_nbeats", 64'(b_log.size()), 64'd24);
    for (int k = 0; k < 24 && k < b_log.size(); k++)
      chk("b_beat", b_log[k], {26'd0, (k < 8), 3'd0, 2'd2, 32'h100 + 32'(4 * (k % 8))});
    for (int k = 0; k < 8; k++) chk("b_mem", 64'(b_mem[k]), 64'(32'h100 + 32'(4 * k)));
    repeat (4) tick();
    chk("a_done_stays_idle", 64'({a_htrans, a_ss}), 64'({2'd0, 1'b1}));

    // Scenario B: 3 wait states on write 0x114, corrupt first read of 0x10C
    wait_en = 1'b1; corrupt_en = 1'b1;
    do_reset("rstB");
    run_to_done(a_done, b_done, chk_cyc);
    chk("B_done_cycle", 64'(a_done), 64'd44);
    chk("B_result", 64'({a_passcount, a_errcount, a_ss, a_sf}), {22'd0, 8'd3, 32'd1, 1'b0, 1'b1});
    chk("B_firsterr", 64'(a_firsterr), 64'h10C);
    chk_a_log("B");
    chk_a_mem("B");
    wait_en = 1'b0; corrupt_en = 1'b0;

    // Scenario C: error response on every read of 0x104
    resp_en = 1'b1;
    do_reset("rstC");
    run_to_done(a_done, b_done, chk_cyc);
    chk("C_done_cycle", 64'(a_done), 64'd41);
    chk("C_result", 64'({a_passcount, a_errcount, a_ss, a_sf}), {22'd0, 8'd3, 32'd3, 1'b0, 1'b1});
    chk("C_firsterr", 64'(a_firsterr), 64'h104);

    // Scenario D: reset mid-burst in the first read pass
    do_reset("rstD");
    begin
      int found;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
        tick();
        if (a_sc && a_htrans == 2'd3 && a_haddr == 32'h118) found = 1;
      end
      chk("D_reached_read_burst", 64'(found), 64'd1);
    end
    chk("D_err_before_reset", 64'({a_errcount, a_firsterr}), {32'd1, 32'h104});
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("D_async");
    resp_en = 1'b0;
    do_reset("rstD2");
    repeat (4) tick();
    chk("D_restart_write", 64'({a_htrans, a_hwrite, a_sw, a_sc}), 64'({2'd2, 1'b1, 1'b1, 1'b0}));
    chk("D_restart_errcount", 64'(a_errcount), 64'd0);
    run_to_done(a_done, b_done, chk_cyc);
    chk("D_result", 64'({a_passcount, a_errcount, a_ss, a_sf}), {22'd0, 8'd3, 32'd0, 1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
